// File: rtl/symbol_framer.sv
// Packs per-cycle convolutional encoder symbols (2 or 3 bits) MSB-first into
// fixed-width frames, zero-padding the final partial frame and flagging it as last.
module symbol_framer #(
    parameter int FRAME_W       = 48,
    parameter int MAX_CODE_RATE = 3,
    parameter int CNT_W         = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_code_rate,
    input  logic                     i_sym_valid,
    input  logic [MAX_CODE_RATE-1:0] i_sym,
    input  logic                     i_sym_last,
    output logic                     o_sym_ready,
    output logic [FRAME_W-1:0]       o_frame_data,
    output logic                     o_frame_valid,
    output logic                     o_frame_last,
    input  logic                     i_frame_ready,
    output logic                     o_busy
);

    localparam logic [CNT_W-1:0] N_RATE2 = CNT_W'(FRAME_W / 2);
    localparam logic [CNT_W-1:0] N_RATE3 = CNT_W'(FRAME_W / 3);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        OUT
    } state_t;

    state_t             state_reg;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] shift_next;
    logic [FRAME_W-1:0] shifted2;
    logic [FRAME_W-1:0] shifted3;
    logic [2:0]         ins_sym;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   n_sel;
    logic               frame_full;
    logic               rate_reg;
    logic               sym_ready_reg;
    logic               frame_valid_reg;
    logic               frame_last_reg;
    logic               busy_reg;

    // Only FILL inserts a real symbol; PAD shifts in zeros.
    always_comb begin
        ins_sym = 3'b000;
        if (state_reg == FILL) begin
            ins_sym = i_sym[2:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_W; gi++) begin : g_shift
            if (gi >= 2) begin : g_hi2
                assign shifted2[gi] = shift_reg[gi-2];
            end else begin : g_lo2
                assign shifted2[gi] = ins_sym[gi];
            end
            if (gi >= 3) begin : g_hi3
                assign shifted3[gi] = shift_reg[gi-3];
            end else begin : g_lo3
                assign shifted3[gi] = ins_sym[gi];
            end
        end
    endgenerate

    assign shift_next = rate_reg ? shifted3 : shifted2;
    assign count_inc  = count_reg + CNT_W'(1);
    assign n_sel      = rate_reg ? N_RATE3 : N_RATE2;
    assign frame_full = (count_inc == n_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            count_reg       <= '0;
            rate_reg        <= 1'b0;
            sym_ready_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_last_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        state_reg     <= FILL;
                        shift_reg     <= '0;
                        count_reg     <= '0;
                        rate_reg      <= i_code_rate;
                        sym_ready_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                FILL: begin
                    if (i_sym_valid) begin
                        shift_reg <= shift_next;
                        count_reg <= count_inc;
                        if (frame_full) begin
                            state_reg       <= OUT;
                            sym_ready_reg   <= 1'b0;
                            frame_valid_reg <= 1'b1;
                            frame_last_reg  <= i_sym_last;
                        end else if (i_sym_last) begin
                            state_reg     <= PAD;
                            sym_ready_reg <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    shift_reg <= shift_next;
                    count_reg <= count_inc;
                    if (frame_full) begin
                        state_reg       <= OUT;
                        frame_valid_reg <= 1'b1;
                        frame_last_reg  <= 1'b1;
                    end
                end
                OUT: begin
                    // Frame data and last flag are held until the downstream takes them.
                    if (i_frame_ready) begin
                        frame_valid_reg <= 1'b0;
                        frame_last_reg  <= 1'b0;
                        count_reg       <= '0;
                        if (frame_last_reg) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg     <= FILL;
                            sym_ready_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_sym_ready   = sym_ready_reg;
    assign o_frame_data  = shift_reg;
    assign o_frame_valid = frame_valid_reg;
    assign o_frame_last  = frame_last_reg;
    assign o_busy        = busy_reg;

endmodule
